// File: rtl/uart_tx_rr_arbiter.sv
// Round-robin arbiter that shares one single-byte UART transmitter among NUM_REQ requesters.
// Latches the winner's byte, strobes tx_en, waits for tx_done (with optional watchdog) and acks.
module uart_tx_rr_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int TX_EN_HOLD  = 4,
  parameter int TIMEOUT_CYC = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*8-1:0]       req_data,
  output logic [NUM_REQ-1:0]         ack,
  output logic                       err,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       tx_en,
  output logic [7:0]                 tx_data,
  input  logic                       tx_done
);

  localparam int ID_W   = $clog2(NUM_REQ);
  localparam int HOLD_W = $clog2(TX_EN_HOLD);

  localparam logic [ID_W-1:0]    LAST_ID   = ID_W'(NUM_REQ - 1);
  localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(TX_EN_HOLD - 1);
  localparam logic [31:0]        WAIT_LAST = 32'(TIMEOUT_CYC - 1);
  localparam logic [NUM_REQ-1:0] ONE_HOT0  = NUM_REQ'(1);

  typedef enum logic [1:0] {IDLE, START, WAIT, ACK} state_t;

  state_t            state;
  logic [ID_W-1:0]   last_grant;
  logic [ID_W-1:0]   winner;
  logic [HOLD_W-1:0] hold_cnt;
  logic [31:0]       wait_cnt;

  // Round-robin search: walk offsets from farthest to nearest so the nearest
  // requester above last_grant is the one left in winner.
  always_comb begin
    int idx;
    // NOTE: every variable written here gets a default first, otherwise an
    // incomplete assignment path infers a latch.
    winner = last_grant;
    idx    = 0;
    for (int off = NUM_REQ; off >= 1; off--) begin
      idx = (int'(last_grant) + off) % NUM_REQ;
      if (req[idx[ID_W-1:0]]) winner = idx[ID_W-1:0];
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= LAST_ID;
      grant_id   <= '0;
      tx_data    <= 8'h00;
      tx_en      <= 1'b0;
      busy       <= 1'b0;
      ack        <= '0;
      err        <= 1'b0;
      hold_cnt   <= '0;
      wait_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            tx_data    <= req_data[{winner, 3'b000} +: 8];
            grant_id   <= winner;
            last_grant <= winner;
            hold_cnt   <= '0;
            tx_en      <= 1'b1;
            busy       <= 1'b1;
            state      <= START;
          end
        end
        START: begin
          if (hold_cnt == HOLD_LAST) begin
            tx_en    <= 1'b0;
            wait_cnt <= '0;
            state    <= WAIT;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        WAIT: begin
          if (wait_cnt != '1) wait_cnt <= wait_cnt + 32'd1;
          // A real completion wins over a watchdog expiry in the same cycle.
          if (tx_done) begin
            ack   <= ONE_HOT0 << grant_id;
            state <= ACK;
          end else if (TIMEOUT_CYC != 0 && wait_cnt == WAIT_LAST) begin
            ack   <= ONE_HOT0 << grant_id;
            err   <= 1'b1;
            state <= ACK;
          end
        end
        ACK: begin
          ack   <= '0;
          err   <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_rr_arbiter.sv
// Self-checking bench for uart_tx_rr_arbiter: directed vector table, hand-written
// corner sequences and randomized transfers against a round-robin reference model.
module tb_uart_tx_rr_arbiter;

  localparam int N    = 4;
  localparam int HOLD = 4;
  localparam int TMO  = 100;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] req;
  logic [N*8-1:0] req_data;
  logic [N-1:0] ack;
  logic         err;
  logic         busy;
  logic [1:0]   grant_id;
  logic         tx_en;
  logic [7:0]   tx_data;
  logic         tx_done;

  uart_tx_rr_arbiter #(
    .NUM_REQ    (N),
    .TX_EN_HOLD (HOLD),
    .TIMEOUT_CYC(TMO)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .req_data(req_data),
    .ack     (ack),
    .err     (err),
    .busy    (busy),
    .grant_id(grant_id),
    .tx_en   (tx_en),
    .tx_data (tx_data),
    .tx_done (tx_done)
  );

  always #5 clk = ~clk;

  int   checks      = 0;
  int   failures    = 0;
  int   cycle_no    = 0;
  int   rise_cycle  = -1000;
  int   stub_delay  = 0;
  int   stray_cycle = -1;
  logic en_prev     = 1'b0;
  int   model_last  = N - 1;

  typedef struct {
    logic [3:0]  req;
    logic [31:0] data;
    int          delay;    // tx_done this many cycles after tx_en rise; 0 = never
    int          stray_k;  // extra tx_done this many cycles after rise; 0 = none
    int          grant;
    logic [7:0]  tx_byte;
    bit          err;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock: advance past the edge, then play the transmitter stub.
  task automatic tick();
    @(posedge clk);
    #1;
    cycle_no++;
    if (tx_en && !en_prev) rise_cycle = cycle_no;
    en_prev = tx_en;
    tx_done = (stub_delay > 0 && cycle_no == rise_cycle + stub_delay) ||
              (cycle_no == stray_cycle);
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    @(negedge clk);
    rst_n      = 1'b1;
    en_prev    = 1'b0;
    model_last = N - 1;
  endtask

  // Reference: the winner is the set bit at the smallest circular distance above last.
  function automatic int rr_model(input logic [3:0] r, input int last);
    int best  = -1;
    int bestd = N;
    for (int i = 0; i < N; i++) begin
      if (r[i] && ((i - last - 1 + N) % N) < bestd) begin
        bestd = (i - last - 1 + N) % N;
        best  = i;
      end
    end
    return best;
  endfunction

  // Drive one full transfer and check its shape, timing and acknowledge.
  task automatic run_txn(input logic [3:0] r, input logic [31:0] d, input int delay,
                         input int stray_k, input int eg, input logic [7:0] eb,
                         input bit eerr, input string tag);
    int         en_cnt, en_last_k, ack_cnt, ack_k, bad, k, exp_k;
    logic [3:0] ack_val;
    logic       err_val;
    en_cnt = 0; en_last_k = -1; ack_cnt = 0; ack_k = -1; bad = 0; k = 0;
    ack_val = '0; err_val = 1'b0;
    exp_k = (delay > 0) ? delay + 1 : HOLD + TMO;
    req = r; req_data = d; stub_delay = delay;
    tick();
    check({tag, "_start"}, {busy, tx_en, grant_id, tx_data}, {1'b1, 1'b1, 2'(eg), eb});
    if (tx_en) begin en_cnt = 1; en_last_k = 0; end
    if (stray_k > 0) stray_cycle = cycle_no + stray_k;
    while (busy && k < 400) begin
      tick();
      k++;
      if (tx_en) begin en_cnt++; en_last_k = k; end
      if (ack != '0) begin
        ack_cnt++; ack_k = k; ack_val = ack; err_val = err;
        req = '0;
      end
      if (err && ack == '0) bad++;
      if (busy && (tx_data !== eb || grant_id !== 2'(eg))) bad++;
    end
    check({tag, "_tx_en_cycles"}, en_cnt, HOLD);
    check({tag, "_tx_en_last"}, en_last_k, HOLD - 1);
    check({tag, "_ack_count"}, ack_cnt, 1);
    check({tag, "_ack_cycle"}, ack_k, exp_k);
    check({tag, "_ack_onehot"}, ack_val, 4'b0001 << eg);
    check({tag, "_err"}, err_val, eerr);
    check({tag, "_busy_fall"}, k, exp_k + 1);
    check({tag, "_stable"}, bad, 0);
    stub_delay = 0;
    model_last = eg;
  endtask

  initial begin
    vec_t vecs[8];
    int   order[6];
    int   exp_order[6];
    int   drop_at[4];
    int   raise_at[4];
    int   g_cnt, bad_oh, idx, eg, dly, k;
    logic [3:0]  r;
    logic [31:0] d;

    exp_order = '{0, 1, 2, 3, 0, 1};
    vecs[0] = '{4'b0100, 32'hD3A55C0E, 44, 0, 2, 8'hA5, 1'b0};
    vecs[1] = '{4'b0010, 32'hD3A55C0E, 20, 2, 1, 8'h5C, 1'b0};
    vecs[2] = '{4'b1010, 32'hD3A55C0E, 15, 0, 3, 8'hD3, 1'b0};
    vecs[3] = '{4'b1010, 32'hD3A55C0E, 15, 0, 1, 8'h5C, 1'b0};
    vecs[4] = '{4'b1001, 32'hD3A55C0E, 12, 1, 3, 8'hD3, 1'b0};
    vecs[5] = '{4'b1001, 32'hD3A55C0E,  0, 0, 0, 8'h0E, 1'b1};
    vecs[6] = '{4'b0110, 32'hD3A55C0E, 30, 0, 1, 8'h5C, 1'b0};
    vecs[7] = '{4'b1111, 32'h01234567,  8, 0, 2, 8'h23, 1'b0};

    rst_n = 1'b0; req = '0; req_data = '0; tx_done = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", {ack, err, busy, tx_en, grant_id, tx_data}, '0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors: single request, simultaneous requests, stray done, watchdog.
    foreach (vecs[i])
      run_txn(vecs[i].req, vecs[i].data, vecs[i].delay, vecs[i].stray_k,
              vecs[i].grant, vecs[i].tx_byte, vecs[i].err, $sformatf("vec%0d", i));

    // Stray tx_done while idle must be ignored.
    req = '0;
    stray_cycle = cycle_no + 1;
    tick();
    tick();
    check("stray_idle", {busy, tx_en, ack, err}, '0);
    tick();
    eg = rr_model(4'b0001, model_last);
    run_txn(4'b0001, 32'hD3A55C0E, 25, 0, eg, 8'h0E, 1'b0, "after_stray");

    // All requesting: each requester drops one cycle after its ack, re-raises two later.
    do_reset();
    req = 4'hF; req_data = 32'hD3A55C0E; stub_delay = 10;
    g_cnt = 0; bad_oh = 0;
    for (int i = 0; i < 4; i++) begin drop_at[i] = -1; raise_at[i] = -1; end
    for (int c = 0; c < 800 && g_cnt < 6; c++) begin
      tick();
      for (int i = 0; i < 4; i++) begin
        if (drop_at[i] == cycle_no) req[i] = 1'b0;
        if (raise_at[i] == cycle_no) req[i] = 1'b1;
      end
      if (ack != '0) begin
        if (!$onehot(ack)) bad_oh++;
        idx = 0;
        for (int i = 0; i < 4; i++) if (ack[i]) idx = i;
        order[g_cnt] = idx;
        g_cnt++;
        drop_at[idx]  = cycle_no + 1;
        raise_at[idx] = cycle_no + 3;
      end
    end
    req = '0; stub_delay = 0;
    check("rr_grant_count", g_cnt, 6);
    check("rr_ack_onehot", bad_oh, 0);
    for (int i = 0; i < 6; i++)
      if (i < g_cnt) check($sformatf("rr_order%0d", i), order[i], exp_order[i]);
    k = 0;
    while (busy && k < 50) begin tick(); k++; end
    check("rr_drain_idle", busy, 1'b0);
    model_last = 1;

    // Reset two cycles into START, then a fresh grant restarts from requester 0.
    req = 4'b0001;
    tick();
    tick();
    tick();
    check("pre_rst_start", {busy, tx_en, grant_id}, {1'b1, 1'b1, 2'd0});
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_outputs", {tx_en, busy, ack, err, grant_id, tx_data}, '0);
    req = 4'b0011;
    @(negedge clk);
    rst_n = 1'b1; en_prev = 1'b0; model_last = N - 1;
    run_txn(4'b0011, 32'hD3A55C0E, 20, 0, 0, 8'h0E, 1'b0, "post_rst");

    // Randomized transfers against the reference model.
    for (int t = 0; t < 20; t++) begin
      r   = 4'($urandom_range(1, 15));
      d   = $urandom;
      dly = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(HOLD, 50));
      eg  = rr_model(r, model_last);
      run_txn(r, d, dly, 0, eg, d[eg*8 +: 8], dly == 0, $sformatf("rand%0d", t));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation exceeded its time limit");
    $fatal(1, "timeout");
  end

endmodule
